// File: rtl/board_move_commit.sv
// board_move_commit: owns the 3x3 tic-tac-toe board. Accepts one move at a
// time, range/occupancy/turn-checks it, commits legal moves, then evaluates
// win/draw and advances the turn.
//
// Handshake: a request transfers on a rising edge where move_valid and
// move_ready are both high. move_ready is high exactly while the FSM is in
// IDLE. move_pos/move_player are sampled only on that edge. Every transferred
// request produces exactly one move_accept or move_reject pulse, unless
// new_game or rst aborts it first.
module board_move_commit #(
    parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_game,
    input  logic                  move_valid,
    output logic                  move_ready,
    input  logic [3:0]            move_pos,
    input  logic [1:0]            move_player,
    output logic [2:0][2:0][1:0]  juego,
    output logic [1:0]            turn,
    output logic                  move_accept,
    output logic                  move_reject,
    output logic [3:0]            move_count,
    output logic [1:0]            winner,
    output logic                  draw,
    output logic                  game_over,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WRITE = 3'd2,
        S_EVAL  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t          state_q;
    logic [8:0][1:0] cells_q;      // cell i = row*3+col
    logic [3:0]      pos_q;
    logic [1:0]      player_q;
    logic [1:0]      turn_q;
    logic [3:0]      count_q;
    logic [1:0]      winner_q;
    logic            draw_q;
    logic            over_q;
    logic            accept_q;
    logic            reject_q;

    logic [1:0]      target_d;
    logic            legal_d;
    logic            win_d;

    function automatic logic three(input logic [1:0] a, input logic [1:0] b,
                                   input logic [1:0] c, input logic [1:0] p);
        return (a == p) && (b == p) && (c == p);
    endfunction

    // Contents of the latched target cell (empty when out of range).
    always_comb begin
        target_d = 2'b00;
        for (int i = 0; i < 9; i++) begin
            if (pos_q == 4'(i)) target_d = cells_q[i];
        end
    end

    // Legality of the latched request against the current board and turn.
    always_comb begin
        legal_d = (pos_q <= 4'd8) && (target_d == 2'b00) &&
                  (player_q == turn_q) &&
                  ((player_q == 2'b01) || (player_q == 2'b10));
    end

    // Any of the 8 lines fully owned by the player that just moved.
    always_comb begin
        win_d = three(cells_q[0], cells_q[1], cells_q[2], player_q) ||
                three(cells_q[3], cells_q[4], cells_q[5], player_q) ||
                three(cells_q[6], cells_q[7], cells_q[8], player_q) ||
                three(cells_q[0], cells_q[3], cells_q[6], player_q) ||
                three(cells_q[1], cells_q[4], cells_q[7], player_q) ||
                three(cells_q[2], cells_q[5], cells_q[8], player_q) ||
                three(cells_q[0], cells_q[4], cells_q[8], player_q) ||
                three(cells_q[2], cells_q[4], cells_q[6], player_q);
    end

    // Move FSM: handshake, check, commit, evaluate; rst/new_game clear all.
    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state_q  <= S_IDLE;
            cells_q  <= '0;
            pos_q    <= '0;
            player_q <= '0;
            turn_q   <= FIRST_PLAYER;
            count_q  <= '0;
            winner_q <= '0;
            draw_q   <= 1'b0;
            over_q   <= 1'b0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (move_valid) begin
                        pos_q    <= move_pos;
                        player_q <= move_player;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (legal_d) begin
                        state_q <= S_WRITE;
                    end else begin
                        reject_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    for (int i = 0; i < 9; i++) begin
                        if (pos_q == 4'(i)) cells_q[i] <= player_q;
                    end
                    count_q <= count_q + 4'd1;
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    accept_q <= 1'b1;
                    if (win_d) begin
                        winner_q <= player_q;
                        over_q   <= 1'b1;
                        state_q  <= S_OVER;
                    end else if (count_q == 4'd9) begin
                        draw_q  <= 1'b1;
                        over_q  <= 1'b1;
                        state_q <= S_OVER;
                    end else begin
                        turn_q  <= (turn_q == 2'b01) ? 2'b10 : 2'b01;
                        state_q <= S_IDLE;
                    end
                end
                S_OVER: begin
                    state_q <= S_OVER;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Packed [row][col][2] has the same bit layout as cell index row*3+col.
    assign juego       = cells_q;
    assign move_ready  = (state_q == S_IDLE);
    assign turn        = turn_q;
    assign move_accept = accept_q;
    assign move_reject = reject_q;
    assign move_count  = count_q;
    assign winner      = winner_q;
    assign draw        = draw_q;
    assign game_over   = over_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_board_move_commit.sv
// Bench for board_move_commit: directed scenarios plus random moves, checked
// by a scoreboard fed from a game-level reference model.
module tb_board_move_commit;

    localparam int W = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 new_game;
    logic                 move_valid;
    logic                 move_ready;
    logic [3:0]           move_pos;
    logic [1:0]           move_player;
    logic [2:0][2:0][1:0] juego;
    logic [1:0]           turn;
    logic                 move_accept;
    logic                 move_reject;
    logic [3:0]           move_count;
    logic [1:0]           winner;
    logic                 draw;
    logic                 game_over;
    logic [2:0]           state_dbg;

    board_move_commit #(.FIRST_PLAYER(2'b01)) dut (
        .clk         (clk),
        .rst         (rst),
        .new_game    (new_game),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .move_pos    (move_pos),
        .move_player (move_player),
        .juego       (juego),
        .turn        (turn),
        .move_accept (move_accept),
        .move_reject (move_reject),
        .move_count  (move_count),
        .winner      (winner),
        .draw        (draw),
        .game_over   (game_over),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;
    int hs_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (game rules) ----------------
    int m_board[9];
    int m_turn, m_count, m_winner, m_draw, m_over;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic void model_clear();
        foreach (m_board[i]) m_board[i] = 0;
        m_turn = 1; m_count = 0; m_winner = 0; m_draw = 0; m_over = 0;
    endfunction

    // Expected word: latency, accept flag, board, turn, count, winner, draw, over.
    function automatic logic [W-1:0] pack_exp(input bit acc, input int lat);
        logic [17:0] b;
        for (int i = 0; i < 9; i++) b[i*2 +: 2] = 2'(m_board[i]);
        return {3'(lat), acc, b, 2'(m_turn), 4'(m_count), 2'(m_winner),
                1'(m_draw), 1'(m_over)};
    endfunction

    function automatic logic [W-1:0] model_move(input int pos, input int pl);
        bit legal;
        bit won;
        legal = (pos <= 8) && (pl == m_turn) && (pl == 1 || pl == 2) && (m_over == 0);
        if (legal && m_board[pos] != 0) legal = 0;
        if (!legal) return pack_exp(1'b0, 1);
        m_board[pos] = pl;
        m_count++;
        won = 0;
        for (int l = 0; l < 8; l++) begin
            if (m_board[lines[l][0]] == pl && m_board[lines[l][1]] == pl &&
                m_board[lines[l][2]] == pl) won = 1;
        end
        if (won) begin
            m_winner = pl; m_over = 1;
        end else if (m_count == 9) begin
            m_draw = 1; m_over = 1;
        end else begin
            m_turn = 3 - m_turn;
        end
        return pack_exp(1'b1, 3);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] act_w;
        logic [W-1:0] exp_w;
        if (move_accept && move_reject) chk("pulse_exclusive", 32'd1, 32'd0);
        if (move_accept || move_reject) begin
            act_w = {3'(cyc - hs_cyc), move_accept, juego, turn, move_count,
                     winner, draw, game_over};
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {31'd0, move_accept}, {31'd0, 1'b0} | {31'd0, move_reject});
                if (!move_reject) chk("unexpected_accept", 32'd1, 32'd0);
            end else begin
                exp_w = exp_q.pop_front();
                chk("scoreboard", act_w, exp_w);
            end
            resp_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (move_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake(input int pos, input int pl, output bit ok);
        wait_ready(ok);
        if (!ok) return;
        move_valid  = 1'b1;
        move_pos    = 4'(pos);
        move_player = 2'(pl);
        @(posedge clk);
        #1;
        hs_cyc      = cyc;
        move_valid  = 1'b0;
        move_pos    = 4'($urandom);
        move_player = 2'($urandom);
    endtask

    task automatic wait_resp(input int base);
        for (int i = 0; i < 12; i++) begin
            if (resp_cnt != base) return;
            @(negedge clk);
        end
        chk("resp_timeout", 32'd0, 32'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic do_move(input int pos, input int pl);
        int base;
        bit ok;
        base = resp_cnt;
        handshake(pos, pl, ok);
        if (!ok) return;
        exp_q.push_back(model_move(pos, pl));
        wait_resp(base);
    endtask

    task automatic check_clear(input string tag);
        chk({tag, "_juego"}, 32'(juego), 32'd0);
        chk({tag, "_turn"}, 32'(turn), 32'd1);
        chk({tag, "_count"}, 32'(move_count), 32'd0);
        chk({tag, "_winner"}, 32'(winner), 32'd0);
        chk({tag, "_draw"}, 32'(draw), 32'd0);
        chk({tag, "_over"}, 32'(game_over), 32'd0);
        chk({tag, "_pulses"}, {30'd0, move_accept, move_reject}, 32'd0);
        chk({tag, "_ready"}, 32'(move_ready), 32'd1);
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
    endtask

    // While the game is over, a held request must never be taken.
    task automatic try_over();
        @(negedge clk);
        move_valid  = 1'b1;
        move_pos    = 4'($urandom_range(0, 8));
        move_player = 2'(m_turn);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("over_ready", 32'(move_ready), 32'd0);
        end
        move_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        bit ok;
        int pos, pl;
        rst = 1'b1; new_game = 1'b0; move_valid = 1'b0;
        move_pos = '0; move_player = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_clear("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_clear("after_reset");

        // First move X@4 with commit timing.
        base = resp_cnt;
        handshake(4, 1, ok);
        exp_q.push_back(model_move(4, 1));
        @(negedge clk);                                    // CHECK
        chk("t1_juego", 32'(juego), 32'd0);
        @(negedge clk);                                    // WRITE
        chk("t2_juego", 32'(juego), 32'd0);
        @(negedge clk);                                    // EVAL
        chk("t3_cell11", 32'(juego[1][1]), 32'd1);
        chk("t3_count", 32'(move_count), 32'd1);
        chk("t3_accept", 32'(move_accept), 32'd0);
        chk("t3_turn", 32'(turn), 32'd1);
        wait_resp(base);
        chk("x4_turn", 32'(turn), 32'd2);

        // Rejects: occupied, out of range, wrong turn, bad player codes.
        do_move(4, 2);
        do_move(9, 2);
        do_move(15, 2);
        do_move(0, 1);
        do_move(0, 0);
        do_move(0, 3);

        // Row-0 win for X.
        pulse_new_game();
        check_clear("ng1");
        do_move(0, 1); do_move(3, 2); do_move(1, 1); do_move(4, 2); do_move(2, 1);
        chk("win_winner", 32'(winner), 32'd1);
        chk("win_turn", 32'(turn), 32'd1);
        try_over();
        // new_game while OVER.
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_clear();
        @(negedge clk);
        check_clear("ng_over");

        // Draw.
        do_move(0, 1); do_move(1, 2); do_move(2, 1); do_move(4, 2); do_move(3, 1);
        do_move(5, 2); do_move(7, 1); do_move(6, 2); do_move(8, 1);
        chk("draw_flag", 32'(draw), 32'd1);
        chk("draw_count", 32'(move_count), 32'd9);
        try_over();
        pulse_new_game();

        // new_game during WRITE aborts the in-flight move.
        do_move(0, 1);
        handshake(4, 2, ok);                               // CHECK period
        @(posedge clk); #1;                                // WRITE period
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_clear();
        @(negedge clk);
        check_clear("ng_write");
        repeat (5) @(negedge clk);

        // new_game coinciding with a handshake drops the request.
        wait_ready(ok);
        move_valid = 1'b1; move_pos = 4'd0; move_player = 2'd1; new_game = 1'b1;
        @(posedge clk); #1;
        move_valid = 1'b0; new_game = 1'b0;
        repeat (5) @(negedge clk);
        check_clear("ng_hs");

        // rst during CHECK.
        do_move(8, 1);
        handshake(0, 2, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check_clear("rst_check");
        repeat (5) @(negedge clk);

        // Random play against the model.
        for (int n = 0; n < 250; n++) begin
            if (m_over != 0) begin
                try_over();
                pulse_new_game();
            end else begin
                pos = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
                pl  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : m_turn;
                do_move(pos, pl);
            end
        end

        repeat (6) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/board_move_commit.md
# board_move_commit

Owns the 3x3 tic-tac-toe board register and is the write side of the board that the move validator and the random position generator read. It accepts one move request at a time over a valid/ready handshake and range/occupancy/turn-checks it. An accepted move is written into the board, then the block evaluates win/draw, advances the turn, and exposes board, turn and result to the VGA and control logic.

## Interface
- FIRST_PLAYER, 2'b01, player code that moves first after reset/new_game (2'b01 = X, 2'b10 = O)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- new_game  in  1  synchronous clear of board and result; no effect while rst=1
- move_valid  in  1  move request present
- move_ready  out  1  block can take a request; combinational, high iff state=IDLE
- move_pos  in  4  cell index 0..8 = row*3+col; 9..15 illegal
- move_player  in  2  requesting player code
- juego  out  [2:0][2:0][1:0]  board, juego[row][col]; 00 empty, 01 X, 10 O, 11 never written
- turn  out  2  player expected next
- move_accept  out  1  one-cycle pulse: request committed
- move_reject  out  1  one-cycle pulse: request refused, board unchanged
- move_count  out  4  committed moves since reset/new_game, 0..9
- winner  out  2  00 none, else winning player code
- draw  out  1  board full, no winner
- game_over  out  1  winner!=00 or draw

## Operation
- States: IDLE, CHECK, WRITE, EVAL, OVER.
- IDLE: handshake when move_valid && move_ready; latch move_pos, move_player; go CHECK.
- CHECK: reject if move_pos>8, or target cell !=00, or move_player!=turn, or move_player in {00,11}. Reject: pulse move_reject, return IDLE. Else go WRITE.
- WRITE: target cell <= latched player; move_count+1; go EVAL.
- EVAL: test 8 lines (3 rows, 3 cols, 2 diagonals) for all three cells == latched player.
  - Win: winner<=player, game_over<=1, go OVER.
  - Else if move_count==9: draw<=1, game_over<=1, go OVER.
  - Else turn toggles 01<->10, go IDLE.
  - move_accept pulses in all three cases; turn is not toggled on win/draw.
- OVER: move_ready=0; holds board and results until new_game or rst.
- new_game (any state): board all 00, turn<=FIRST_PLAYER, move_count/winner/draw/game_over <=0, state IDLE; in-flight move aborted with no accept/reject pulse.
- rst: same effect as new_game and overrides it; move_accept=move_reject=0.
- Reset values: juego all 00, turn=FIRST_PLAYER, move_count=0, winner=00, draw=0, game_over=0, move_accept=0, move_reject=0, move_ready=1.
- move_count is 4-bit unsigned and never exceeds 9; no wrap.

## Timing
- Handshake in cycle t.
- Reject path: CHECK at t+1; move_reject high in t+2 only; move_ready high again in t+2.
- Accept path: CHECK t+1, WRITE t+2; juego and move_count updated from t+3.
- EVAL t+3; move_accept high in t+4 only. turn/winner/draw/game_over take new values from t+4. move_ready high in t+4 unless OVER.
- Throughput: at most one request per 2 cycles (rejects) or 4 cycles (accepts).
- move_pos/move_player are sampled only at the handshake; later changes have no effect.
- new_game asserted in the same cycle as a handshake wins: request dropped, never pulses.
- move_accept and move_reject are never high together.

## Test plan
- Reset, then X pos 4 at t -> juego[1][1]=01 from t+3; move_accept at t+4; turn=10; move_count=1.
- Cell 4 already X, O requests pos 4 -> move_reject at t+2; board and turn unchanged. Repeat with pos 9 and pos 15 -> reject each.
- X requests while turn=10 -> reject. Player 00 or 11 -> reject.
- Sequence X0,O3,X1,O4,X2 -> fifth move_accept with winner=01, game_over=1, turn stays 01. move_ready=0; further requests are not handshaked.
- Full-board sequence X0,O1,X2,O4,X3,O5,X7,O6,X8 -> draw=1, winner=00, move_count=9.
- new_game asserted in WRITE and then in OVER -> next cycle board cleared, turn=FIRST_PLAYER, no pulses. rst during CHECK -> all reset values.
